// File: rtl/ycc_block_aligner.sv
`default_nettype none
// ============================================================================
// Module   : ycc_block_aligner
// Purpose  : Collects one 8x8 luma block and the matching upsampled 8x8 Cb and
//            Cr blocks in any arrival order. Once all three are held, it
//            streams them out one aligned (Y,Cb,Cr) pixel row per beat.
//            Every interface uses valid/ready handshakes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   system clock; all state changes on the rising edge
//   reset_n    in   asynchronous, active-low reset
//   y_valid    in   y_block holds a full luma block
//   y_block    in   luma block, [row][col]
//   y_ready    out  luma slot is empty and the aligner is filling
//   c_valid    in   chroma block valid (from supersample_4x4 valid_out)
//   c_ch       in   2'b01 = Cb, 2'b10 = Cr, other codes are illegal
//   c_block    in   chroma block, [row][col]
//   c_ready    out  slot chosen by c_ch is empty, or c_ch is illegal
//   out_valid  out  out_* carry a valid pixel row
//   out_ready  in   downstream accepts the current row
//   out_row    out  row index of the current beat
//   out_y      out  Y row,  out_y[c]  = y_block[out_row][c]
//   out_cb     out  Cb row, same indexing
//   out_cr     out  Cr row, same indexing
//   out_last   out  high together with out_valid on the final row
//   err_ch     out  one-cycle pulse after an illegal c_ch block was dropped
// ============================================================================
module ycc_block_aligner #(
  parameter int DATA_W = 9,
  parameter int N      = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,

  input  logic                             y_valid,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  y_block,
  output logic                             y_ready,

  input  logic                             c_valid,
  input  logic [1:0]                       c_ch,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  c_block,
  output logic                             c_ready,

  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2:0]                       out_row,
  output logic [N-1:0][DATA_W-1:0]         out_y,
  output logic [N-1:0][DATA_W-1:0]         out_cb,
  output logic [N-1:0][DATA_W-1:0]         out_cr,
  output logic                             out_last,
  output logic                             err_ch
);

  localparam logic [1:0] CH_CB    = 2'b01;
  localparam logic [1:0] CH_CR    = 2'b10;
  localparam logic [2:0] LAST_ROW = 3'(N - 1);
  localparam logic [2:0] PEN_ROW  = 3'(N - 2);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state;

  // Block storage. The data itself carries no reset: the full flags are the
  // only thing that says a slot holds something, and the output muxes are
  // gated by out_valid, so stale contents can never leak out.
  logic [N-1:0][N-1:0][DATA_W-1:0] y_slot;
  logic [N-1:0][N-1:0][DATA_W-1:0] cb_slot;
  logic [N-1:0][N-1:0][DATA_W-1:0] cr_slot;
  logic                            y_full;
  logic                            cb_full;
  logic                            cr_full;
  logic [2:0]                      row;

  logic ch_is_cb;
  logic ch_is_cr;
  logic ch_illegal;
  logic filling;
  logic acc_y;
  logic acc_cb;
  logic acc_cr;
  logic drop_c;
  logic all_full;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign ch_is_cb   = (c_ch == CH_CB);
  assign ch_is_cr   = (c_ch == CH_CR);
  assign ch_illegal = !(ch_is_cb || ch_is_cr);
  assign filling    = (state == FILL);

  assign y_ready = filling && !y_full;
  // Illegal codes are always consumed while filling so a bad source cannot
  // wedge the chroma port; they are dropped and flagged on err_ch.
  assign c_ready = filling && (ch_illegal ||
                               (ch_is_cb && !cb_full) ||
                               (ch_is_cr && !cr_full));

  assign acc_y    = y_valid && y_ready;
  assign acc_cb   = c_valid && c_ready && ch_is_cb;
  assign acc_cr   = c_valid && c_ready && ch_is_cr;
  assign drop_c   = c_valid && c_ready && ch_illegal;
  assign all_full = y_full && cb_full && cr_full;

  // --------------------------------------------------------------------------
  // Slot data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (acc_y) begin
      y_slot <= y_block;
    end
    if (acc_cb) begin
      cb_slot <= c_block;
    end
    if (acc_cr) begin
      cr_slot <= c_block;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: full flags, row counter and registered status outputs.
  // The move to STREAM looks at the registered full flags, so the last
  // accept is followed by exactly one FILL cycle before the first beat.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      row       <= 3'd0;
      y_full    <= 1'b0;
      cb_full   <= 1'b0;
      cr_full   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_ch    <= 1'b0;
    end else begin
      err_ch <= drop_c;

      case (state)
        FILL: begin
          if (acc_y) begin
            y_full <= 1'b1;
          end
          if (acc_cb) begin
            cb_full <= 1'b1;
          end
          if (acc_cr) begin
            cr_full <= 1'b1;
          end
          if (all_full) begin
            state     <= STREAM;
            row       <= 3'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end

        STREAM: begin
          // Without out_ready nothing changes, which keeps every out_*
          // stable for as long as the consumer stalls.
          if (out_ready) begin
            if (row == LAST_ROW) begin
              state     <= FILL;
              row       <= 3'd0;
              y_full    <= 1'b0;
              cb_full   <= 1'b0;
              cr_full   <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              row      <= row + 3'd1;
              out_last <= (row == PEN_ROW);
            end
          end
        end

        default: begin
          state     <= FILL;
          row       <= 3'd0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Row output: a straight mux out of the slots, zeroed between blocks.
  // --------------------------------------------------------------------------
  assign out_row = row;

  always_comb begin
    out_y  = '0;
    out_cb = '0;
    out_cr = '0;
    if (out_valid) begin
      out_y  = y_slot[row];
      out_cb = cb_slot[row];
      out_cr = cr_slot[row];
    end
  end

endmodule
`default_nettype wire
